// File: rtl/bcd_ssg_pkg.sv
// Shared constants and the BCD-to-segment decoder for the BCD counter/display block.
package bcd_ssg_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned SEG_W      = 7;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] d);
        case (d)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_counter_ssg_mux_digit.sv
// One BCD digit cell: load, up/down step with combinational carry/borrow out.
module bcd_digit
    import bcd_ssg_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             step_en,
    input  logic             up_down,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out_c
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            // Non-BCD load data is stored as zero
            digit_d = (load_digit > 4'd9) ? 4'd0 : load_digit;
        end else if (step_en && carry_in) begin
            if (up_down) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            else         digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
        end
    end

    assign carry_out_c = carry_in & (up_down ? (digit_q == 4'd9) : (digit_q == 4'd0));
    assign digit       = digit_q;

    always_ff @(posedge clock) begin
        if (reset) digit_q <= '0;
        else       digit_q <= digit_d;
    end

endmodule

// File: rtl/bcd_counter_ssg_mux.sv
// Multi-digit BCD up/down counter with multiplexed active-low seven-segment driver.
module bcd_counter_ssg_mux
    import bcd_ssg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV_W = 11,
    parameter int unsigned SCAN_DIV_W = 5,
    parameter int unsigned LZ_BLANK   = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        up_down,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    output logic [BCD_W*NUM_DIGITS-1:0] count_bcd,
    output logic                        wrap,
    output logic [SEG_W-1:0]            seg,
    output logic                        dp,
    output logic [NUM_DIGITS-1:0]       an
);

    localparam int unsigned CNT_W = BCD_W * NUM_DIGITS;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [TICK_DIV_W-1:0] pre_q, pre_d;
    logic [SCAN_DIV_W-1:0] scan_pre_q, scan_pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wrap_q, wrap_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic                  tick_c;
    logic [NUM_DIGITS:0]   carry_c;
    logic [CNT_W-1:0]      count_c;
    logic [BCD_W-1:0]      digit_sel_c;
    logic                  blank_c;

    assign tick_c     = enable & (pre_q == '1);
    assign carry_c[0] = 1'b1;

    // Ripple carry/borrow chain, digit 0 is least significant
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clock      (clock),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[BCD_W*g +: BCD_W]),
            .step_en    (tick_c),
            .up_down    (up_down),
            .carry_in   (carry_c[g]),
            .digit      (count_c[BCD_W*g +: BCD_W]),
            .carry_out_c(carry_c[g+1])
        );
    end

    always_comb begin
        pre_d       = pre_q;
        scan_pre_d  = scan_pre_q + SCAN_DIV_W'(1);
        idx_d       = idx_q;
        wrap_d      = tick_c & ~load & carry_c[NUM_DIGITS];
        digit_sel_c = '0;
        blank_c     = (LZ_BLANK != 0) && (idx_q != '0);
        an_d        = '1;

        if (load)        pre_d = '0;
        else if (enable) pre_d = pre_q + TICK_DIV_W'(1);

        if (scan_pre_q == '1)
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

        // Blank only if this digit and every digit above it are zero
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                digit_sel_c = count_c[BCD_W*i +: BCD_W];
                an_d[i]     = 1'b0;
            end
            if ((IDX_W'(i) >= idx_q) && (count_c[BCD_W*i +: BCD_W] != 4'd0))
                blank_c = 1'b0;
        end

        seg_d = blank_c ? SEG_BLANK : bcd_to_seg(digit_sel_c);
        dp_d  = !((idx_q == '0) && !enable);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q      <= '0;
            scan_pre_q <= '0;
            idx_q      <= '0;
            wrap_q     <= 1'b0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            pre_q      <= pre_d;
            scan_pre_q <= scan_pre_d;
            idx_q      <= idx_d;
            wrap_q     <= wrap_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign count_bcd = count_c;
    assign wrap      = wrap_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign an        = an_q;

endmodule
